batch_output_arbiter: RTL and testbench
=======================================

BATCH_OUTPUT_ARBITER -- requirements
Module: batch_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_PARALLEL_INSTANCES, default 4: number of upstream conflict-detection instances merged (power of two, 2..16).
REQ-002 SHALL have parameter MAX_DEPENDENCIES, default 256: width of each read/write dependency bitmap.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 64: idle cycles tolerated inside a granted batch before the grant is abandoned.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port s_axis_tvalid, input, NUM_PARALLEL_INSTANCES: per-instance valid.
REQ-007 SHALL have port s_axis_tready, output, NUM_PARALLEL_INSTANCES: per-instance ready.
REQ-008 SHALL have port s_axis_tdata_owner_programID, input, NUM_PARALLEL_INSTANCES x 64: per-instance programID.
REQ-009 SHALL have ports s_axis_tdata_read_dependencies and s_axis_tdata_write_dependencies, input, NUM_PARALLEL_INSTANCES x MAX_DEPENDENCIES each.
REQ-010 SHALL have port s_axis_tlast, input, NUM_PARALLEL_INSTANCES: marks the final beat of an instance's batch.
REQ-011 SHALL have ports m_axis_tvalid (output, 1) and m_axis_tready (input, 1).
REQ-012 SHALL have ports m_axis_tdata_owner_programID (64), m_axis_tdata_read_dependencies and m_axis_tdata_write_dependencies (MAX_DEPENDENCIES each), all outputs.
REQ-013 SHALL have ports m_axis_tlast (1) and m_axis_tdest ($clog2(NUM_PARALLEL_INSTANCES)), outputs: the batch-end flag and the source instance index.
REQ-014 SHALL have outputs batches_forwarded (32), beats_forwarded (32) and lock_timeouts (32): monitoring counters.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and LOCKED; the FSM leaves reset in IDLE.
REQ-016 IDLE: if any s_axis_tvalid is high, the FSM SHALL register grant = first requester at or after rr_ptr (wrapping), go to LOCKED next cycle, and drive all s_axis_tready low in this cycle.
REQ-017 LOCKED: only s_axis_tready[grant] may be high; it SHALL equal slot_free = !m_axis_tvalid || m_axis_tready.
REQ-018 A beat is accepted when s_axis_tvalid[grant] && s_axis_tready[grant]; the output register SHALL load data, tlast and tdest=grant on the next edge.
REQ-019 Latency: an input valid arriving in IDLE with the output empty SHALL appear on m_axis_tvalid two cycles later; sustained streaming in LOCKED SHALL achieve 1 beat/cycle.
REQ-020 m_axis_tvalid SHALL clear only when m_axis_tready is high and no new beat loads in the same cycle; payload SHALL be stable while valid && !ready.
REQ-021 Accepting a beat with tlast=1 SHALL return the FSM to IDLE and set rr_ptr = grant+1 mod NUM_PARALLEL_INSTANCES; batches are never interleaved.
REQ-022 In LOCKED, an idle counter SHALL count cycles with s_axis_tvalid[grant] low and reset on any accepted beat; on reaching LOCK_TIMEOUT_CYCLES the FSM SHALL go to IDLE, rr_ptr = grant+1, lock_timeouts += 1, and no synthetic tlast is emitted.
REQ-023 Valid-high cycles stalled by the output SHALL NOT advance the idle counter.
REQ-024 Counters SHALL wrap modulo 2^32: beats_forwarded increments per output handshake; batches_forwarded increments per output handshake with m_axis_tlast=1.

Reset
REQ-025 On rst, the FSM SHALL enter IDLE, rr_ptr=0, grant=0, idle counter=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdest=0, payload=0, and all counters =0; s_axis_tready SHALL be all-zero during reset.
REQ-026 rst asserted mid-batch SHALL discard the in-flight output beat and the lock; no recovery of the partial batch.

Configuration
REQ-027 With BATCH_ARB_PERF_COUNTERS_EN defined, the three counters SHALL operate per REQ-022/REQ-024; without it, the ports SHALL remain and be tied to 0, with no counter flops.

Structure
REQ-028 The package svm_sched_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and the programID width constant (64).
REQ-029 The output register SHALL be a sub-module named axis_reg_slice, parameterised by payload width.

Verification
REQ-030 Instance 2 sends 3 beats (last on the 3rd), m_axis_tready=1 -> tdest=2 on 3 consecutive beats, first valid 2 cycles after input valid, batches_forwarded=1.
REQ-031 All 4 instances send 1-beat batches simultaneously after reset -> output order tdest 0,1,2,3; rr_ptr wraps back to 0.
REQ-032 Instance 0 is mid-batch while instance 1 is valid -> no instance-1 beat appears until instance 0's tlast beat is accepted.
REQ-033 m_axis_tready is held low 5 cycles with a beat pending -> payload stable, s_axis_tready[grant]=0, idle counter unchanged.
REQ-034 Granted instance 3 stops after 1 beat with no tlast -> after 64 idle cycles the FSM returns to IDLE, lock_timeouts=1, and the next grant goes to instance 0.
REQ-035 rst pulsed while m_axis_tvalid=1 -> the next cycle has m_axis_tvalid=0, all counters 0 and the FSM in IDLE.

Source files
------------

// File: rtl/svm_sched_pkg.sv
// Shared scheduler types: arbiter FSM states and the programID width.
package svm_sched_pkg;

  localparam int unsigned PROGRAM_ID_W = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-stream register slice; payload held stable while valid && !ready.
module axis_reg_slice #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Slot can take a new beat when empty or being drained this cycle.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/batch_output_arbiter.sv
// Merges per-instance batch streams into one, locking onto a source until its tlast beat.
// Optional monitoring counters enabled by BATCH_ARB_PERF_COUNTERS_EN.
module batch_output_arbiter
  import svm_sched_pkg::*;
#(
  parameter int unsigned NUM_PARALLEL_INSTANCES = 4,
  parameter int unsigned MAX_DEPENDENCIES       = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES    = 64
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [NUM_PARALLEL_INSTANCES-1:0]                      s_axis_tvalid,
  output logic [NUM_PARALLEL_INSTANCES-1:0]                      s_axis_tready,
  input  logic [NUM_PARALLEL_INSTANCES-1:0][PROGRAM_ID_W-1:0]     s_axis_tdata_owner_programID,
  input  logic [NUM_PARALLEL_INSTANCES-1:0][MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [NUM_PARALLEL_INSTANCES-1:0][MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  input  logic [NUM_PARALLEL_INSTANCES-1:0]                      s_axis_tlast,
  output logic                                                   m_axis_tvalid,
  input  logic                                                   m_axis_tready,
  output logic [PROGRAM_ID_W-1:0]                                m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0]                            m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]                            m_axis_tdata_write_dependencies,
  output logic                                                   m_axis_tlast,
  output logic [$clog2(NUM_PARALLEL_INSTANCES)-1:0]              m_axis_tdest,
  output logic [31:0]                                            batches_forwarded,
  output logic [31:0]                                            beats_forwarded,
  output logic [31:0]                                            lock_timeouts
);

  localparam int unsigned IDX_W  = $clog2(NUM_PARALLEL_INSTANCES);
  localparam int unsigned IDLE_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned PAY_W  = 1 + IDX_W + PROGRAM_ID_W + 2 * MAX_DEPENDENCIES;

  arb_state_e        r_state;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDLE_W-1:0] r_idle_cnt;

  logic              w_locked;
  logic              w_grant_valid;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_timeout;
  logic              w_any_req;
  logic [IDX_W-1:0]  w_pick;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_next_ptr;
  logic [PAY_W-1:0]  w_slice_in;
  logic [PAY_W-1:0]  w_slice_out;

  // Reset masks the lock combinationally so no handshake can occur while rst is high.
  assign w_locked      = (r_state == LOCKED) && !rst;
  assign w_grant_valid = s_axis_tvalid[r_grant];
  assign w_accept      = w_locked && w_grant_valid && w_slot_free;
  assign w_timeout     = w_locked && !w_grant_valid &&
                         (r_idle_cnt == IDLE_W'(LOCK_TIMEOUT_CYCLES - 1));
  assign w_next_ptr    = IDX_W'(r_grant + IDX_W'(1));

  always_comb begin
    s_axis_tready = '0;
    if (w_locked) s_axis_tready[r_grant] = w_slot_free;
  end

  // Round-robin pick: first requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_any_req = 1'b0;
    w_pick    = r_rr_ptr;
    w_idx     = r_rr_ptr;
    for (int unsigned k = 0; k < NUM_PARALLEL_INSTANCES; k++) begin
      w_idx = IDX_W'(r_rr_ptr + IDX_W'(k));
      if (!w_any_req && s_axis_tvalid[w_idx]) begin
        w_any_req = 1'b1;
        w_pick    = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant    <= w_pick;
            r_state    <= LOCKED;
            r_idle_cnt <= '0;
          end
        end
        LOCKED: begin
          if (w_accept) begin
            r_idle_cnt <= '0;
            if (s_axis_tlast[r_grant]) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end else if (w_timeout) begin
            r_state    <= IDLE;
            r_rr_ptr   <= w_next_ptr;
            r_idle_cnt <= '0;
          end else if (!w_grant_valid) begin
            // Output-stalled cycles with valid high are not idle.
            r_idle_cnt <= IDLE_W'(r_idle_cnt + IDLE_W'(1));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_slice_in = {s_axis_tlast[r_grant], r_grant,
                       s_axis_tdata_owner_programID[r_grant],
                       s_axis_tdata_read_dependencies[r_grant],
                       s_axis_tdata_write_dependencies[r_grant]};

  axis_reg_slice #(
    .DATA_W (PAY_W)
  ) u_out_slice (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_locked && w_grant_valid),
    .o_ready (w_slot_free),
    .i_data  (w_slice_in),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready),
    .o_data  (w_slice_out)
  );

  assign {m_axis_tlast, m_axis_tdest, m_axis_tdata_owner_programID,
          m_axis_tdata_read_dependencies, m_axis_tdata_write_dependencies} = w_slice_out;

`ifdef BATCH_ARB_PERF_COUNTERS_EN
  logic        w_out_hs;
  logic [31:0] r_batches;
  logic [31:0] r_beats;
  logic [31:0] r_timeouts;

  assign w_out_hs = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_batches  <= '0;
      r_beats    <= '0;
      r_timeouts <= '0;
    end else begin
      if (w_out_hs)                 r_beats    <= r_beats + 32'(1);
      if (w_out_hs && m_axis_tlast) r_batches  <= r_batches + 32'(1);
      if (w_timeout)                r_timeouts <= r_timeouts + 32'(1);
    end
  end

  assign batches_forwarded = r_batches;
  assign beats_forwarded   = r_beats;
  assign lock_timeouts     = r_timeouts;
`else
  assign batches_forwarded = '0;
  assign beats_forwarded   = '0;
  assign lock_timeouts     = '0;
`endif

endmodule

// File: tb/tb_batch_output_arbiter.sv
// Scoreboard bench for batch_output_arbiter: round-robin batch model, directed and random traffic.
module tb_batch_output_arbiter;

  localparam int unsigned NI = 4;
  localparam int unsigned MD = 256;
  localparam int unsigned TO = 64;
  localparam int unsigned IW = 2;

  typedef struct {
    logic [63:0]   pid;
    logic [MD-1:0] rd;
    logic [MD-1:0] wr;
    logic          last;
  } beat_t;

  typedef struct {
    beat_t         b;
    logic [IW-1:0] dest;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NI-1:0]          s_axis_tvalid;
  logic [NI-1:0]          s_axis_tready;
  logic [NI-1:0][63:0]    s_axis_tdata_owner_programID;
  logic [NI-1:0][MD-1:0]  s_axis_tdata_read_dependencies;
  logic [NI-1:0][MD-1:0]  s_axis_tdata_write_dependencies;
  logic [NI-1:0]          s_axis_tlast;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [63:0]            m_axis_tdata_owner_programID;
  logic [MD-1:0]          m_axis_tdata_read_dependencies;
  logic [MD-1:0]          m_axis_tdata_write_dependencies;
  logic                   m_axis_tlast;
  logic [IW-1:0]          m_axis_tdest;
  logic [31:0]            batches_forwarded;
  logic [31:0]            beats_forwarded;
  logic [31:0]            lock_timeouts;

  batch_output_arbiter #(
    .NUM_PARALLEL_INSTANCES (NI),
    .MAX_DEPENDENCIES       (MD),
    .LOCK_TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .s_axis_tdata_owner_programID    (s_axis_tdata_owner_programID),
    .s_axis_tdata_read_dependencies  (s_axis_tdata_read_dependencies),
    .s_axis_tdata_write_dependencies (s_axis_tdata_write_dependencies),
    .s_axis_tlast                    (s_axis_tlast),
    .m_axis_tvalid                   (m_axis_tvalid),
    .m_axis_tready                   (m_axis_tready),
    .m_axis_tdata_owner_programID    (m_axis_tdata_owner_programID),
    .m_axis_tdata_read_dependencies  (m_axis_tdata_read_dependencies),
    .m_axis_tdata_write_dependencies (m_axis_tdata_write_dependencies),
    .m_axis_tlast                    (m_axis_tlast),
    .m_axis_tdest                    (m_axis_tdest),
    .batches_forwarded               (batches_forwarded),
    .beats_forwarded                 (beats_forwarded),
    .lock_timeouts                   (lock_timeouts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t src_q   [NI][$];
  beat_t stage_q [NI][$];
  beat_t tmp_q   [NI][$];
  exp_t  exp_q [$];
  int    hs_cyc [$];

  int n_tests = 0;
  int n_fail  = 0;
  int mdl_ptr = 0;
  int exp_beats = 0;
  int exp_batches = 0;
  int exp_timeouts = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic last);
    beat_t b;
    b.pid = {$urandom, $urandom};
    for (int w = 0; w < int'(MD / 32); w++) begin
      b.rd[w*32 +: 32] = $urandom;
      b.wr[w*32 +: 32] = $urandom;
    end
    b.last = last;
    return b;
  endfunction

  task automatic stage_batch(input int inst, input int len);
    for (int k = 0; k < len; k++) stage_q[inst].push_back(mk_beat(k == len - 1));
  endtask

  // Reference: staged batches appear together; each grant takes one whole batch, round-robin.
  task automatic commit();
    int    found;
    beat_t b;
    exp_t  e;
    for (int i = 0; i < int'(NI); i++) tmp_q[i] = stage_q[i];
    forever begin
      found = -1;
      for (int k = 0; k < int'(NI); k++)
        if (found < 0 && tmp_q[(mdl_ptr + k) % NI].size() > 0) found = (mdl_ptr + k) % NI;
      if (found < 0) break;
      do begin
        b = tmp_q[found].pop_front();
        e.b = b;
        e.dest = IW'(found);
        exp_q.push_back(e);
      end while (!b.last && tmp_q[found].size() > 0);
      mdl_ptr = (found + 1) % NI;
    end
    for (int i = 0; i < int'(NI); i++)
      while (stage_q[i].size() > 0) src_q[i].push_back(stage_q[i].pop_front());
  endtask

  // Source and sink driver: inputs change on the falling edge, handshakes resolved before the rising edge.
  initial begin
    logic [NI-1:0] acc;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata_owner_programID    = '0;
    s_axis_tdata_read_dependencies  = '0;
    s_axis_tdata_write_dependencies = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NI); i++) begin
        if (src_q[i].size() > 0) begin
          s_axis_tvalid[i] = 1'b1;
          s_axis_tlast[i]  = src_q[i][0].last;
          s_axis_tdata_owner_programID[i]    = src_q[i][0].pid;
          s_axis_tdata_read_dependencies[i]  = src_q[i][0].rd;
          s_axis_tdata_write_dependencies[i] = src_q[i][0].wr;
        end else begin
          s_axis_tvalid[i] = 1'b0;
          s_axis_tlast[i]  = 1'b0;
        end
      end
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 1'b0;
      endcase
      #1;
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      for (int i = 0; i < int'(NI); i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  end

  // Monitor: every output handshake is checked against the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && m_axis_tvalid && m_axis_tready) begin
        hs_cyc.push_back(cyc);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got dest=%0d pid=%h with nothing expected",
                   m_axis_tdest, m_axis_tdata_owner_programID);
        end else begin
          e = exp_q.pop_front();
          exp_beats++;
          if (e.b.last) exp_batches++;
          if (m_axis_tdest !== e.dest || m_axis_tlast !== e.b.last ||
              m_axis_tdata_owner_programID !== e.b.pid ||
              m_axis_tdata_read_dependencies !== e.b.rd ||
              m_axis_tdata_write_dependencies !== e.b.wr) begin
            n_fail++;
            $display("FAIL beat: got dest=%0d last=%0b pid=%h, expected dest=%0d last=%0b pid=%h, rd_ok=%0b wr_ok=%0b",
                     m_axis_tdest, m_axis_tlast, m_axis_tdata_owner_programID,
                     e.dest, e.b.last, e.b.pid,
                     m_axis_tdata_read_dependencies === e.b.rd,
                     m_axis_tdata_write_dependencies === e.b.wr);
          end
        end
      end
    end
  end

  function automatic bit all_src_empty();
    for (int i = 0; i < int'(NI); i++) if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int max_cyc);
    int k = 0;
    while (!(exp_q.size() == 0 && all_src_empty()) && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_mvalid(input string name);
    int k = 0;
    while (m_axis_tvalid !== 1'b1 && k < 20) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk({name, "_mvalid"}, 64'(m_axis_tvalid), 64'd1);
  endtask

  task automatic check_counters(input string name);
    @(posedge clk);
    #2;
`ifdef BATCH_ARB_PERF_COUNTERS_EN
    chk({name, "_batches"},  64'(batches_forwarded), 64'(exp_batches));
    chk({name, "_beats"},    64'(beats_forwarded),   64'(exp_beats));
    chk({name, "_timeouts"}, 64'(lock_timeouts),     64'(exp_timeouts));
`else
    chk({name, "_batches"},  64'(batches_forwarded), 64'd0);
    chk({name, "_beats"},    64'(beats_forwarded),   64'd0);
    chk({name, "_timeouts"}, 64'(lock_timeouts),     64'd0);
`endif
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NI); i++) begin
      src_q[i].delete();
      stage_q[i].delete();
    end
    exp_q.delete();
    mdl_ptr = 0;
    exp_beats = 0;
    exp_batches = 0;
    exp_timeouts = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [63:0]   cap_pid;
    logic [IW-1:0] cap_dest;

    // Reset state, with a requester present during reset.
    repeat (2) @(posedge clk);
    #2;
    src_q[1].push_back(mk_beat(1'b1));
    @(posedge clk);
    #2;
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdest",    64'(m_axis_tdest),  64'd0);
    chk("rst_tlast",    64'(m_axis_tlast),  64'd0);
    chk("rst_pid",      m_axis_tdata_owner_programID, 64'd0);
    chk("rst_deps",     64'(|{m_axis_tdata_read_dependencies, m_axis_tdata_write_dependencies}), 64'd0);
    check_counters("rst");
    clear_model();
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("idle_no_output", 64'(m_axis_tvalid), 64'd0);

    // Instance 2 sends a 3-beat batch; latency and back-to-back streaming.
    ready_mode = 0;
    hs_cyc.delete();
    stage_batch(2, 3);
    commit();
    c0 = cyc;
    wait_drain("single", 50);
    chk("single_hs_count", 64'(hs_cyc.size()), 64'd3);
    if (hs_cyc.size() == 3) begin
      chk("single_latency", 64'(hs_cyc[0] - c0), 64'd2);
      chk("single_stream",  64'(hs_cyc[2] - hs_cyc[0]), 64'd2);
    end
    check_counters("single");

    // Reset while an output beat is pending.
    ready_mode = 2;
    stage_batch(1, 3);
    commit();
    wait_mvalid("rstmid");
    @(posedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    #2;
    chk("rstmid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rstmid_s_tready", 64'(s_axis_tready), 64'd0);
    rst = 1'b0;
    ready_mode = 0;
    check_counters("rstmid");
    repeat (4) @(posedge clk);
    #2;
    chk("rstmid_no_recover", 64'(m_axis_tvalid), 64'd0);

    // All four instances request together; then pointer wrap check.
    for (int i = 0; i < int'(NI); i++) stage_batch(i, 1);
    commit();
    wait_drain("rr4", 100);
    stage_batch(3, 1);
    stage_batch(0, 1);
    commit();
    wait_drain("rrwrap", 100);

    // Output stall longer than the timeout with the granted source still valid.
    ready_mode = 2;
    stage_batch(1, 2);
    stage_batch(2, 1);
    commit();
    wait_mvalid("stall");
    cap_pid  = m_axis_tdata_owner_programID;
    cap_dest = m_axis_tdest;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      chk("stall_pid",      m_axis_tdata_owner_programID, cap_pid);
      chk("stall_dest",     64'(m_axis_tdest), 64'(cap_dest));
      chk("stall_s_tready", 64'(s_axis_tready[1]), 64'd0);
    end
    repeat (TO + 2) @(posedge clk);
    #2;
    ready_mode = 0;
    wait_drain("stall", 100);
    check_counters("stall");

    // Instance 1 becomes valid while instance 0 is mid-batch.
    ready_mode = 1;
    stage_batch(0, 4);
    commit();
    repeat (2) @(posedge clk);
    #2;
    stage_batch(1, 2);
    commit();
    wait_drain("nointerleave", 200);

    // Granted instance 3 stalls without tlast; others wait for the timeout.
    ready_mode = 0;
    hs_cyc.delete();
    begin
      exp_t e;
      e.b = mk_beat(1'b0);
      e.dest = IW'(3);
      exp_q.push_back(e);
      src_q[3].push_back(e.b);
    end
    repeat (5) @(posedge clk);
    #2;
    exp_timeouts++;
    mdl_ptr = 0;
    stage_batch(0, 1);
    stage_batch(2, 1);
    commit();
    wait_drain("timeout", 300);
    chk("timeout_hs_count", 64'(hs_cyc.size()), 64'd3);
    if (hs_cyc.size() >= 2) chk("timeout_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'(TO + 2));
    check_counters("timeout");

    // Randomized batches against the round-robin model.
    for (int r = 0; r < 15; r++) begin
      ready_mode = $urandom_range(0, 1);
      for (int i = 0; i < int'(NI); i++) begin
        int nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) stage_batch(i, $urandom_range(1, 4));
      end
      commit();
      wait_drain("random", 3000);
    end
    check_counters("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
